// File: rtl/camfifo_emulator_if.sv
// rtl/camfifo_emulator_if.sv - FIFO pin bundle between capture controller and camera/FIFO emulator
`timescale 1ns/1ps
interface camfifo_emulator_if #(
    parameter int PTR_W = 18
) ();
    logic             fifo_rck;
    logic             fifo_wen;
    logic             fifo_rrstn;
    logic             vsync;
    logic             href;
    logic [7:0]       fifo_data;
    logic [7:0]       frame_id;
    logic [PTR_W-1:0] wr_count;
    logic             underrun;

    modport master (
        output fifo_rck, fifo_wen, fifo_rrstn,
        input  vsync, href, fifo_data, frame_id, wr_count, underrun
    );

    modport slave (
        input  fifo_rck, fifo_wen, fifo_rrstn,
        output vsync, href, fifo_data, frame_id, wr_count, underrun
    );
endinterface

// File: rtl/camfifo_emulator.sv
// rtl/camfifo_emulator.sv - OV7670 + AL422B stand-in: frame timing and a memoryless virtual FIFO
`timescale 1ns/1ps
module camfifo_emulator #(
    parameter int CLK_DIV      = 2,
    parameter int LINE_BYTES   = 640,
    parameter int H_BLANK      = 144,
    parameter int ACTIVE_LINES = 240,
    parameter int VSYNC_LINES  = 3,
    parameter int V_BACK       = 17,
    parameter int V_FRONT      = 10,
    parameter int PTR_W        = 18
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    camfifo_emulator_if.slave  bus
);
    localparam int LINE_LEN   = LINE_BYTES + H_BLANK;
    localparam int FRAME_ROWS = VSYNC_LINES + V_BACK + ACTIVE_LINES + V_FRONT;
    localparam int ACT_START  = VSYNC_LINES + V_BACK;
    localparam int ACT_END    = ACT_START + ACTIVE_LINES;
    localparam int DIV_W      = $clog2(CLK_DIV + 1);
    localparam int COL_W      = $clog2(LINE_LEN + 1);
    localparam int ROW_W      = $clog2(FRAME_ROWS + 1);

    logic [DIV_W-1:0] div;
    logic [COL_W-1:0] col, col_n;
    logic [ROW_W-1:0] row, row_n;
    logic             frame_wrap;
    logic             tick;
    logic             vsync, href;
    logic [7:0]       frame_id;
    logic [PTR_W-1:0] wptr, rptr, wr_count;
    logic [7:0]       stored_frame;
    logic [7:0]       fifo_data;
    logic             underrun;
    logic             rck_q;
    logic             wr, rd_rise;

    assign tick    = (div == DIV_W'(CLK_DIV - 1));
    assign wr      = tick & href & bus.fifo_wen & vsync;
    assign rd_rise = bus.fifo_rck & ~rck_q;

    // Outputs are registered from the next counter values so they line up with the counters.
    always_comb begin
        col_n      = col;
        row_n      = row;
        frame_wrap = 1'b0;
        if (tick) begin
            if (col == COL_W'(LINE_LEN - 1)) begin
                col_n = '0;
                if (row == ROW_W'(FRAME_ROWS - 1)) begin
                    row_n      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    row_n = row + 1'b1;
                end
            end else begin
                col_n = col + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            div          <= '0;
            col          <= '0;
            row          <= '0;
            vsync        <= 1'b0;
            href         <= 1'b0;
            frame_id     <= '0;
            wptr         <= '0;
            rptr         <= '0;
            wr_count     <= '0;
            stored_frame <= '0;
            fifo_data    <= 8'h00;
            underrun     <= 1'b0;
            rck_q        <= 1'b0;
        end else begin
            div   <= tick ? '0 : div + 1'b1;
            col   <= col_n;
            row   <= row_n;
            vsync <= (row_n >= ROW_W'(VSYNC_LINES));
            href  <= (row_n >= ROW_W'(ACT_START)) && (row_n < ROW_W'(ACT_END)) &&
                     (col_n < COL_W'(LINE_BYTES));
            if (frame_wrap)
                frame_id <= frame_id + 8'd1;

            // VSYNC low doubles as the write-pointer reset, as on the real module.
            if (!vsync) begin
                wptr <= '0;
            end else if (wr) begin
                if (wptr == '0) begin
                    stored_frame <= frame_id;
                    wr_count     <= PTR_W'(1);
                end else begin
                    wr_count     <= wptr + 1'b1;
                end
                wptr <= wptr + 1'b1;
            end

            // Reads see the pre-write wr_count and stored_frame when both happen on one edge.
            rck_q <= bus.fifo_rck;
            if (rd_rise) begin
                if (!bus.fifo_rrstn) begin
                    rptr     <= '0;
                    underrun <= 1'b0;
                end else if (rptr < wr_count) begin
                    fifo_data <= rptr[7:0] + stored_frame;
                    rptr      <= rptr + 1'b1;
                end else begin
                    fifo_data <= 8'hEE;
                    underrun  <= 1'b1;
                    rptr      <= rptr + 1'b1;
                end
            end
        end
    end

    assign bus.vsync     = vsync;
    assign bus.href      = href;
    assign bus.fifo_data = fifo_data;
    assign bus.frame_id  = frame_id;
    assign bus.wr_count  = wr_count;
    assign bus.underrun  = underrun;
endmodule

// File: tb/tb_camfifo_emulator.sv
// tb/tb_camfifo_emulator.sv - scoreboard bench for camfifo_emulator with a frame-level reference model
`timescale 1ns/1ps
module tb_camfifo_emulator;
    localparam int CLK_DIV  = 1;
    localparam int LB       = 4;
    localparam int HB       = 2;
    localparam int AL       = 3;
    localparam int VL       = 1;
    localparam int VB       = 1;
    localparam int VF       = 1;
    localparam int PW       = 18;
    localparam int LINE_LEN = LB + HB;
    localparam int ROWS     = VL + VB + AL + VF;
    localparam int FRAME    = LINE_LEN * ROWS * CLK_DIV;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    camfifo_emulator_if #(.PTR_W(PW)) bus ();

    camfifo_emulator #(
        .CLK_DIV(CLK_DIV), .LINE_BYTES(LB), .H_BLANK(HB), .ACTIVE_LINES(AL),
        .VSYNC_LINES(VL), .V_BACK(VB), .V_FRONT(VF), .PTR_W(PW)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int byte_idx(input int c);
        return c / CLK_DIV;
    endfunction
    function automatic bit exp_vsync(input int c);
        int row = (byte_idx(c) / LINE_LEN) % ROWS;
        return row >= VL;
    endfunction
    function automatic bit exp_href(input int c);
        int row = (byte_idx(c) / LINE_LEN) % ROWS;
        int col = byte_idx(c) % LINE_LEN;
        return (row >= VL + VB) && (row < VL + VB + AL) && (col < LB);
    endfunction
    function automatic int exp_frame(input int c);
        return (byte_idx(c) / (LINE_LEN * ROWS)) % 256;
    endfunction

    // Reference model: cycle count since reset, bytes captured in the current burst.
    int cyc = 0;
    bit m_valid = 1'b0;
    int m_wptr = 0;
    int m_wc = 0;
    int m_sf = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            cyc = 0; m_wptr = 0; m_wc = 0; m_sf = 0; m_valid = 1'b1;
        end else begin
            if (!exp_vsync(cyc)) begin
                m_wptr = 0;
            end else if (exp_href(cyc) && bus.fifo_wen && (cyc % CLK_DIV == CLK_DIV - 1)) begin
                if (m_wptr == 0) m_sf = exp_frame(cyc);
                m_wptr++;
                m_wc = m_wptr;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("vsync", bus.vsync, exp_vsync(cyc));
            check("href", bus.href, exp_href(cyc));
            check("frame_id", bus.frame_id, exp_frame(cyc));
            check("wr_count", bus.wr_count, m_wc);
        end
    end

    typedef struct { logic [7:0] data; logic under; } rd_t;
    rd_t exp_q[$];
    int t_rptr = 0;
    bit t_under = 1'b0;
    logic [7:0] t_data = 8'h00;

    bit pend = 1'b0;
    logic prev_rck = 1'b0;
    always @(negedge clk) begin
        rd_t e;
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL read_queue: DUT read with no expected entry");
            end else begin
                e = exp_q.pop_front();
                check("read_data", bus.fifo_data, e.data);
                check("read_underrun", bus.underrun, e.under);
            end
        end
        if (bus.fifo_rck && !prev_rck) pend = 1'b1;
        prev_rck = bus.fifo_rck;
    end

    task automatic rck_pulse(input bit rr, input int gap);
        @(posedge clk); #1;
        bus.fifo_rrstn = rr;
        bus.fifo_rck = 1'b1;
        if (!rr) begin
            t_rptr = 0;
            t_under = 1'b0;
        end else if (t_rptr < m_wc) begin
            t_data = 8'((t_rptr + m_sf) % 256);
            t_rptr++;
        end else begin
            t_data = 8'hEE;
            t_under = 1'b1;
            t_rptr++;
        end
        exp_q.push_back('{data: t_data, under: t_under});
        @(posedge clk); #1;
        bus.fifo_rck = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic read_reset_seq();
        rck_pulse(1'b0, 0);
        rck_pulse(1'b0, 0);
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
        check("rst_vsync", bus.vsync, 0);
        check("rst_href", bus.href, 0);
        check("rst_fifo_data", bus.fifo_data, 0);
        check("rst_frame_id", bus.frame_id, 0);
        check("rst_wr_count", bus.wr_count, 0);
        check("rst_underrun", bus.underrun, 0);
        exp_q.delete();
        t_rptr = 0; t_under = 1'b0; t_data = 8'h00;
        rstn = 1'b1;
    endtask

    task automatic wait_phase(input int ph, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (cyc % FRAME == ph) return;
        end
        tests++; fails++;
        $display("FAIL wait_phase: phase %0d not reached in %0d cycles", ph, budget);
    endtask

    initial begin
        int n;
        bus.fifo_rck = 1'b0;
        bus.fifo_wen = 1'b0;
        bus.fifo_rrstn = 1'b1;
        do_reset(2);

        // Free run with wen low through the first frame wrap.
        repeat (40) @(posedge clk);

        // Capture frame 1.
        wait_phase(8, 3 * FRAME);
        bus.fifo_wen = 1'b1;
        wait_phase(0, 3 * FRAME);
        bus.fifo_wen = 1'b0;
        check("wr_count_frame1", bus.wr_count, 12);

        // Full readout, then one read past the end, then re-read after read reset.
        read_reset_seq();
        for (int i = 0; i < 12; i++) rck_pulse(1'b1, 0);
        check("last_byte", bus.fifo_data, 8'h0C);
        check("no_underrun", bus.underrun, 0);
        rck_pulse(1'b1, 0);
        check("overread_data", bus.fifo_data, 8'hEE);
        check("overread_underrun", bus.underrun, 1);
        read_reset_seq();
        rck_pulse(1'b1, 0);
        check("reread_byte0", bus.fifo_data, 8'h01);
        check("reread_underrun", bus.underrun, 0);

        // wen held across a whole frame boundary: the VSYNC pulse restarts the burst.
        wait_phase(20, 3 * FRAME);
        bus.fifo_wen = 1'b1;
        wait_phase(0, 3 * FRAME);
        wait_phase(1, 3 * FRAME);
        wait_phase(0, 3 * FRAME);
        bus.fifo_wen = 1'b0;
        check("wr_count_span", bus.wr_count, 12);
        read_reset_seq();
        for (int i = 0; i < 12; i++) rck_pulse(1'b1, 0);

        // Random write-enable patterns and random read counts/spacing.
        for (int it = 0; it < 5; it++) begin
            wait_phase(1, 3 * FRAME);
            for (int c = 1; c < FRAME; c++) begin
                bus.fifo_wen = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            bus.fifo_wen = 1'b0;
            read_reset_seq();
            n = $urandom_range(1, m_wc + 2);
            for (int i = 0; i < n; i++) rck_pulse(1'b1, $urandom_range(0, 2));
        end

        // Reset in the middle of a read burst.
        wait_phase(1, 3 * FRAME);
        bus.fifo_wen = 1'b1;
        wait_phase(0, 3 * FRAME);
        bus.fifo_wen = 1'b0;
        read_reset_seq();
        for (int i = 0; i < 3; i++) rck_pulse(1'b1, 0);
        do_reset(1);
        read_reset_seq();
        rck_pulse(1'b1, 0);
        check("post_reset_read", bus.fifo_data, 8'hEE);
        check("post_reset_underrun", bus.underrun, 1);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL read_queue_drain: %0d expected reads never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end
endmodule
